// File: rtl/ex_muldiv_if.sv
// ID/EX <-> multiply/divide unit handshake and operand bus.
interface ex_muldiv_if #(
  parameter int XLEN = 32
);
  logic            start_i;
  logic            flush_i;
  logic [2:0]      funct3_i;
  logic [XLEN-1:0] rs1_i;
  logic [XLEN-1:0] rs2_i;
  logic            stall_o;
  logic            busy_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;

  // Pipeline side: issues ops, observes stall/result.
  modport master (
    output start_i, flush_i, funct3_i, rs1_i, rs2_i,
    input  stall_o, busy_o, done_o, result_o
  );

  // Unit side.
  modport slave (
    input  start_i, flush_i, funct3_i, rs1_i, rs2_i,
    output stall_o, busy_o, done_o, result_o
  );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Multiply is shift-add over a 2*XLEN product held in {hi_q, lo_q};
// divide is restoring with the remainder in hi_q (one guard bit) and the
// dividend shifting out of lo_q as quotient bits shift in.
module ex_muldiv #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  ex_muldiv_if.slave  bus
);
  localparam int N  = XLEN / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e          state_q, state_d;
  logic [2:0]      f3_q, f3_d;
  logic            neg_q, neg_d;
  logic [XLEN:0]   hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] opb_q, opb_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            done_q, done_d;

  // Operand decode for the accept cycle.
  logic            a_sgn, b_sgn, a_neg, b_neg, is_div, div0, ovf;
  logic [XLEN-1:0] a_mag, b_mag, fast_res;

  // Decode signedness, magnitudes and the two fast-path cases from live inputs.
  always_comb begin
    is_div = bus.funct3_i[2];
    a_sgn  = (bus.funct3_i == 3'b001) || (bus.funct3_i == 3'b010) ||
             (bus.funct3_i == 3'b100) || (bus.funct3_i == 3'b110);
    b_sgn  = (bus.funct3_i == 3'b001) || (bus.funct3_i == 3'b100) ||
             (bus.funct3_i == 3'b110);
    a_neg  = a_sgn & bus.rs1_i[XLEN-1];
    b_neg  = b_sgn & bus.rs2_i[XLEN-1];
    a_mag  = a_neg ? -bus.rs1_i : bus.rs1_i;
    b_mag  = b_neg ? -bus.rs2_i : bus.rs2_i;
    div0   = is_div && (bus.rs2_i == '0);
    ovf    = is_div && !bus.funct3_i[0] && !div0 &&
             (bus.rs1_i == {1'b1, {(XLEN-1){1'b0}}}) && (bus.rs2_i == '1);
    if (div0)
      fast_res = bus.funct3_i[1] ? bus.rs1_i : '1;
    else
      fast_res = bus.funct3_i[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end

  // One CALC cycle worth of iterations (BITS_PER_CYCLE steps).
  logic [XLEN:0]   s_hi, s_tmp;
  logic [XLEN-1:0] s_lo;

  always_comb begin
    s_hi  = hi_q;
    s_lo  = lo_q;
    s_tmp = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (f3_q[2]) begin
        // shift next dividend bit into the remainder, subtract if it fits
        s_tmp = {s_hi[XLEN-1:0], s_lo[XLEN-1]};
        s_lo  = {s_lo[XLEN-2:0], 1'b0};
        if (s_tmp >= {1'b0, opb_q}) begin
          s_tmp   = s_tmp - {1'b0, opb_q};
          s_lo[0] = 1'b1;
        end
        s_hi = s_tmp;
      end else begin
        // add multiplicand when multiplier LSB set, then shift product right
        s_tmp = {1'b0, s_hi[XLEN-1:0]} + (s_lo[0] ? {1'b0, opb_q} : '0);
        s_lo  = {s_tmp[0], s_lo[XLEN-1:1]};
        s_hi  = {1'b0, s_tmp[XLEN:1]};
      end
    end
  end

  // Sign fix-up and result select applied on the last CALC cycle.
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   quo, remd, fin;

  always_comb begin
    prod   = {s_hi[XLEN-1:0], s_lo};
    prod_s = neg_q ? -prod : prod;
    quo    = neg_q ? -s_lo : s_lo;
    remd   = neg_q ? -s_hi[XLEN-1:0] : s_hi[XLEN-1:0];
    case (f3_q)
      3'b000:                 fin = prod_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fin = prod_s[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fin = quo;
      default:                fin = remd;
    endcase
  end

  // Next-state logic: flush beats everything, otherwise IDLE -> CALC -> DONE.
  always_comb begin
    state_d  = state_q;
    f3_d     = f3_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opb_d    = opb_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    done_d   = 1'b0;
    if (bus.flush_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (bus.start_i) begin
          f3_d  = bus.funct3_i;
          // remainder follows the dividend; everything else follows the product/quotient
          neg_d = (is_div && bus.funct3_i[1]) ? a_neg : (a_neg ^ b_neg);
          cnt_d = CW'(N);
          if (div0 || ovf) begin
            result_d = fast_res;
            done_d   = 1'b1;
            state_d  = DONE;
          end else begin
            hi_d    = '0;
            lo_d    = is_div ? a_mag : b_mag;
            opb_d   = is_div ? b_mag : a_mag;
            state_d = CALC;
          end
        end
        CALC: begin
          hi_d  = s_hi;
          lo_d  = s_lo;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            result_d = fin;
            done_d   = 1'b1;
            state_d  = DONE;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      f3_q     <= '0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      opb_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      f3_q     <= f3_d;
      neg_q    <= neg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opb_q    <= opb_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  // Stall is combinational so the accept cycle already holds ID/EX;
  // reset forces it low even with start_i held.
  assign bus.stall_o  = rst & bus.start_i & (state_q != DONE) & ~bus.flush_i;
  assign bus.busy_o   = (state_q != IDLE);
  assign bus.done_o   = done_q;
  assign bus.result_o = result_q;
endmodule
